// File: rtl/perf_record_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : perf_record_reader                                       |
// | Description : Pops tagged L1I/L1D/L2 miss words from the perf FIFO and |
// |               reassembles them into one valid/ready output frame.      |
// |               Optional partial-frame timeout: PERF_RD_TIMEOUT_EN.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module perf_record_reader #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_rd_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [11:0] l1i_miss,
    output logic [11:0] l1d_miss,
    output logic [11:0] l2_miss,
    output logic [15:0] frame_count,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_CHECK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] C_TAG_L1I = 8'h61;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [11:0] sh_l1i_q, sh_l1i_d;
    logic [11:0] sh_l1d_q, sh_l1d_d;
    logic [11:0] l1i_q, l1i_d;
    logic [11:0] l1d_q, l1d_d;
    logic [11:0] l2_q, l2_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [7:0]  ecnt_q, ecnt_d;

    logic [7:0]  w_exp_tag;
    logic        w_fmt_ok;
    logic        w_word_good;
    logic        w_l1i_good;
    logic        w_abort;

    // Tags are consecutive ASCII letters, so the expected tag is 'a' + idx.
    assign w_exp_tag   = C_TAG_L1I + {6'd0, idx_q};
    assign w_fmt_ok    = (fifo_rd_data[15:12] == 4'd0);
    assign w_word_good = (fifo_rd_data[31:24] == w_exp_tag) &&
                         (fifo_rd_data[23:16] == w_exp_tag) && w_fmt_ok;
    assign w_l1i_good  = (fifo_rd_data[31:24] == C_TAG_L1I) &&
                         (fifo_rd_data[23:16] == C_TAG_L1I) && w_fmt_ok;

`ifdef PERF_RD_TIMEOUT_EN
    localparam int C_TW = $clog2(TIMEOUT_CYC + 1);

    logic [C_TW-1:0] tmo_q;
    logic            w_tmo_run;

    assign w_tmo_run = (state_q == S_FETCH) && (idx_q != 2'd0) && fifo_empty;
    assign w_abort   = w_tmo_run && (tmo_q == C_TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !w_tmo_run || w_abort) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_abort      = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sh_l1i_d   = sh_l1i_q;
        sh_l1d_d   = sh_l1d_q;
        l1i_d      = l1i_q;
        l1d_d      = l1d_q;
        l2_d       = l2_q;
        fcnt_d     = fcnt_q;
        ecnt_d     = ecnt_q;
        fifo_rd_en = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (!fifo_empty) begin
                    fifo_rd_en = !rst;
                    state_d    = S_CHECK;
                end else if (w_abort) begin
                    idx_d    = 2'd0;
                    sh_l1i_d = '0;
                    sh_l1d_d = '0;
                    ecnt_d   = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
                end
            end
            S_CHECK: begin
                state_d = S_FETCH;
                if (w_word_good) begin
                    if (idx_q == 2'd0) begin
                        sh_l1i_d = fifo_rd_data[11:0];
                        idx_d    = 2'd1;
                    end else if (idx_q == 2'd1) begin
                        sh_l1d_d = fifo_rd_data[11:0];
                        idx_d    = 2'd2;
                    end else begin
                        l1i_d   = sh_l1i_q;
                        l1d_d   = sh_l1d_q;
                        l2_d    = fifo_rd_data[11:0];
                        idx_d   = 2'd0;
                        state_d = S_HOLD;
                    end
                end else begin
                    ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
                    // A stray L1I word is treated as the start of a new record.
                    if (w_l1i_good) begin
                        sh_l1i_d = fifo_rd_data[11:0];
                        idx_d    = 2'd1;
                    end else begin
                        idx_d = 2'd0;
                    end
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    fcnt_d  = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            idx_q    <= 2'd0;
            sh_l1i_q <= '0;
            sh_l1d_q <= '0;
            l1i_q    <= '0;
            l1d_q    <= '0;
            l2_q     <= '0;
            fcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sh_l1i_q <= sh_l1i_d;
            sh_l1d_q <= sh_l1d_d;
            l1i_q    <= l1i_d;
            l1d_q    <= l1d_d;
            l2_q     <= l2_d;
            fcnt_q   <= fcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign frame_valid = (state_q == S_HOLD);
    assign l1i_miss    = l1i_q;
    assign l1d_miss    = l1d_q;
    assign l2_miss     = l2_q;
    assign frame_count = fcnt_q;
    assign err_count   = ecnt_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_record_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_perf_record_reader                                    |
// | Description : Directed self-checking bench for perf_record_reader.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_perf_record_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = 32'd0;
    logic        frame_valid;
    logic        frame_ready;
    logic [11:0] l1i_miss, l1d_miss, l2_miss;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:511];
    logic [15:0] wr_ptr = 16'd0;
    logic [15:0] rd_ptr = 16'd0;

    perf_record_reader #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .l1i_miss     (l1i_miss),
        .l1d_miss     (l1d_miss),
        .l2_miss      (l2_miss),
        .frame_count  (frame_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after the pop strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr[8:0]];
            rd_ptr       <= rd_ptr + 16'd1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[8:0]] = w;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (frame_valid !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, frame_valid}, 32'd1);
    endtask

    task automatic chk_frame(input string tag, input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c);
        chk({tag, "_l1i"}, {20'd0, l1i_miss}, {20'd0, a});
        chk({tag, "_l1d"}, {20'd0, l1d_miss}, {20'd0, b});
        chk({tag, "_l2"},  {20'd0, l2_miss},  {20'd0, c});
    endtask

    initial begin
        logic        stable;
        logic [15:0] rd_snap;
        int          k;

        rst         = 1'b1;
        frame_ready = 1'b1;
        push(32'h61610005);
        push(32'h62620123);
        push(32'h63630FFF);
        tick(3);

        // Reset state, FIFO non-empty but must not be popped
        chk("rst_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_rd_ptr",  {16'd0, rd_ptr}, 32'd0);
        chk("rst_valid",   {31'd0, frame_valid}, 32'd0);
        chk_frame("rst", 12'h000, 12'h000, 12'h000);
        chk("rst_fcnt",    {16'd0, frame_count}, 32'd0);
        chk("rst_ecnt",    {24'd0, err_count}, 32'd0);

        // Clean frame: first pop now, frame_valid exactly 6 cycles later
        rst = 1'b0;
        #1;
        chk("clean_first_pop", {31'd0, fifo_rd_en}, 32'd1);
        tick(5);
        chk("clean_not_early", {31'd0, frame_valid}, 32'd0);
        tick(1);
        chk("clean_valid", {31'd0, frame_valid}, 32'd1);
        chk_frame("clean", 12'h005, 12'h123, 12'hFFF);
        tick(1);
        chk("clean_pulse", {31'd0, frame_valid}, 32'd0);
        chk("clean_fcnt",  {16'd0, frame_count}, 32'd1);
        chk("clean_ecnt",  {24'd0, err_count}, 32'd0);

        // Backpressure: two frames queued, consumer stalls 20 cycles
        frame_ready = 1'b0;
        push(32'h61610111);
        push(32'h62620222);
        push(32'h63630333);
        push(32'h61610AAA);
        push(32'h62620555);
        push(32'h63630000);
        wait_valid("bp_valid1", 20);
        chk_frame("bp1", 12'h111, 12'h222, 12'h333);
        rd_snap = rd_ptr;
        stable  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (frame_valid !== 1'b1 || fifo_rd_en !== 1'b0 || l1i_miss !== 12'h111 ||
                l1d_miss !== 12'h222 || l2_miss !== 12'h333)
                stable = 1'b0;
        end
        chk("bp_hold_stable", {31'd0, stable}, 32'd1);
        chk("bp_no_pop",      {16'd0, rd_ptr}, {16'd0, rd_snap});
        chk("bp_fcnt_held",   {16'd0, frame_count}, 32'd1);
        frame_ready = 1'b1;
        tick(1);
        chk("bp_fcnt_acc",    {16'd0, frame_count}, 32'd2);
        chk("bp_next_pop",    {31'd0, fifo_rd_en}, 32'd1);
        wait_valid("bp_valid2", 20);
        chk_frame("bp2", 12'hAAA, 12'h555, 12'h000);
        tick(1);
        chk("bp_fcnt2",       {16'd0, frame_count}, 32'd3);

        // Resync after an out-of-order word
        push(32'h61610001);
        push(32'h63630002);
        push(32'h61610003);
        push(32'h62620004);
        push(32'h63630005);
        wait_valid("rs_valid", 40);
        chk_frame("rs", 12'h003, 12'h004, 12'h005);
        chk("rs_ecnt", {24'd0, err_count}, 32'd1);
        tick(1);
        chk("rs_fcnt", {16'd0, frame_count}, 32'd4);
        push(32'h61611001);
        tick(6);
        chk("rs_nib_ecnt",  {24'd0, err_count}, 32'd2);
        chk("rs_nib_valid", {31'd0, frame_valid}, 32'd0);

        // Reset after two good words
        push(32'h61610111);
        push(32'h62620222);
        tick(5);
        rst = 1'b1;
        tick(1);
        chk_frame("mid_rst", 12'h000, 12'h000, 12'h000);
        chk("mid_rst_fcnt", {16'd0, frame_count}, 32'd0);
        chk("mid_rst_ecnt", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        push(32'h61610007);
        push(32'h62620008);
        push(32'h63630009);
        wait_valid("mid_valid", 20);
        chk_frame("mid", 12'h007, 12'h008, 12'h009);
        tick(1);
        chk("mid_fcnt", {16'd0, frame_count}, 32'd1);
        chk("mid_ecnt", {24'd0, err_count}, 32'd0);

        // Saturation: 300 bad words
        for (int i = 0; i < 300; i++) push(32'h00000000);
        k = 0;
        while (rd_ptr != wr_ptr && k < 2000) begin
            tick(1);
            k++;
        end
        tick(3);
        chk("sat_drained", {16'd0, rd_ptr}, {16'd0, wr_ptr});
        chk("sat_ecnt",    {24'd0, err_count}, 32'hFF);
        chk("sat_fcnt",    {16'd0, frame_count}, 32'd1);

        // Partial frame then long idle gap
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("tmo_rst_ecnt", {24'd0, err_count}, 32'd0);
        push(32'h61610011);
        push(32'h62620022);
        tick(30);
        chk("tmo_valid_idle", {31'd0, frame_valid}, 32'd0);
`ifdef PERF_RD_TIMEOUT_EN
        chk("tmo_ecnt", {24'd0, err_count}, 32'd1);
        push(32'h61610044);
        push(32'h62620055);
        push(32'h63630066);
        wait_valid("tmo_valid", 20);
        chk_frame("tmo", 12'h044, 12'h055, 12'h066);
`else
        chk("notmo_ecnt", {24'd0, err_count}, 32'd0);
        push(32'h63630033);
        wait_valid("notmo_valid", 20);
        chk_frame("notmo", 12'h011, 12'h022, 12'h033);
`endif
        tick(1);
        chk("tmo_fcnt", {16'd0, frame_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
